// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator FSM and mem_responder.
// The initiator drives the request fields; the responder returns data and status.
interface mem_responder_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2
);
  logic              valid;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;

  modport master (
    output valid, rw, addr, wdata,
    input  rdata, ack, busy
  );

  modport slave (
    input  valid, rw, addr, wdata,
    output rdata, ack, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Small register-array memory behind a valid/ack handshake with a fixed access delay.
// Each request is captured in IDLE, serviced after ACCESS_CYCLES, acked once, then waits for valid to drop.
module mem_responder #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned ADDR_W        = 2,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] ACK    = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              capture;
  logic              complete;

  logic              cap_rw;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  // Next-state logic; request fields are only looked at in IDLE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.valid) begin
          state_next = ACCESS;
          cnt_next   = CNT_W'(ACCESS_CYCLES - 1);
          capture    = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_next = ACK;
          complete   = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ACK: begin
        state_next = bus.valid ? HOLD : IDLE;
      end
      HOLD: begin
        if (!bus.valid) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counter and status outputs, registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.ack  <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      bus.ack  <= (state_next == ACK);
      bus.busy <= (state_next != IDLE);
    end
  end

  // Request capture so later bus changes cannot disturb an access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_rw    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (capture) begin
      cap_rw    <= bus.rw;
      cap_addr  <= bus.addr;
      cap_wdata <= bus.wdata;
    end
  end

  // Storage array, cleared by reset and written only as a write completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (complete && cap_rw) begin
      mem[cap_addr] <= cap_wdata;
    end
  end

  // Read data is loaded on the completing edge so it is valid alongside ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rdata <= '0;
    end else if (complete && !cap_rw) begin
      bus.rdata <= mem[cap_addr];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with ACCESS_CYCLES=2, one with ACCESS_CYCLES=1.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(8), .ADDR_W(2)) b0 ();
  mem_responder_if #(.DATA_W(8), .ADDR_W(2)) b1 ();

  mem_responder #(.DATA_W(8), .ADDR_W(2), .ACCESS_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );
  mem_responder #(.DATA_W(8), .ADDR_W(2), .ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mm0 [4];
  logic [7:0] mm1 [4];
  logic [7:0] mr0;
  logic [7:0] mr1;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  task automatic drive(input int sel, input logic v, input logic r,
                       input logic [1:0] a, input logic [7:0] d);
    if (sel == 0) begin
      b0.valid = v; b0.rw = r; b0.addr = a; b0.wdata = d;
    end else begin
      b1.valid = v; b1.rw = r; b1.addr = a; b1.wdata = d;
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < 4; i++) begin
      mm0[i] = 8'h00;
      mm1[i] = 8'h00;
    end
    mr0 = 8'h00;
    mr1 = 8'h00;
    q0.delete();
    q1.delete();
  endtask

  // Issue one request; valid stays high for 'hold' cycles counted from the accept edge.
  // After the accept edge the other request fields are scrambled to prove they are ignored.
  task automatic do_req(input int sel, input logic r, input logic [1:0] a,
                        input logic [7:0] d, input int hold);
    int         ac;
    int         end_e;
    logic       ak;
    logic       bz;
    logic [7:0] rd;
    logic [7:0] want;
    ac    = (sel == 0) ? 2 : 1;
    end_e = (hold > ac + 1) ? hold : ac + 1;

    bz = (sel == 0) ? b0.busy : b1.busy;
    rd = (sel == 0) ? b0.rdata : b1.rdata;
    checks++;
    if (bz !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy dut%0d: got %b want 0", sel, bz);
    end
    want = (sel == 0) ? mr0 : mr1;
    checks++;
    if (rd !== want) begin
      errors++;
      $display("FAIL rdata_held dut%0d: got %h want %h", sel, rd, want);
    end

    if (sel == 0) begin
      if (r) mm0[a] = d; else mr0 = mm0[a];
      q0.push_back(mr0);
    end else begin
      if (r) mm1[a] = d; else mr1 = mm1[a];
      q1.push_back(mr1);
    end

    drive(sel, 1'b1, r, a, d);
    for (int e = 0; e <= end_e; e++) begin
      @(posedge clk);
      #1;
      drive(sel, (e < hold - 1), ~r, ~a, ~d);
      @(negedge clk);
      ak = (sel == 0) ? b0.ack : b1.ack;
      bz = (sel == 0) ? b0.busy : b1.busy;
      rd = (sel == 0) ? b0.rdata : b1.rdata;
      checks++;
      if (ak !== (e == ac)) begin
        errors++;
        $display("FAIL ack dut%0d edge %0d: got %b want %b", sel, e, ak, (e == ac));
      end
      checks++;
      if (bz !== (e < end_e)) begin
        errors++;
        $display("FAIL busy dut%0d edge %0d: got %b want %b", sel, e, bz, (e < end_e));
      end
      if (ak === 1'b1) begin
        checks++;
        if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
          errors++;
          $display("FAIL ack_unexpected dut%0d edge %0d: got ack want no pending request", sel, e);
        end else begin
          want = (sel == 0) ? q0.pop_front() : q1.pop_front();
          if (rd !== want) begin
            errors++;
            $display("FAIL rdata_ack dut%0d addr %0d: got %h want %h", sel, a, rd, want);
          end
        end
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if ({b0.ack, b0.busy, b0.rdata} !== 10'h0) begin
      errors++;
      $display("FAIL %s dut0: got ack=%b busy=%b rdata=%h want all 0", tag, b0.ack, b0.busy, b0.rdata);
    end
    checks++;
    if ({b1.ack, b1.busy, b1.rdata} !== 10'h0) begin
      errors++;
      $display("FAIL %s dut1: got ack=%b busy=%b rdata=%h want all 0", tag, b1.ack, b1.busy, b1.rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(1, 1'b0, 1'b0, 2'd0, 8'h00);
    clear_models();
    @(negedge clk);
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("idle_after_reset");
  endtask

  task automatic test_write_read();
    do_req(0, 1'b1, 2'd2, 8'hA5, 1);
    do_req(0, 1'b0, 2'd2, 8'h00, 1);
    do_req(0, 1'b0, 2'd1, 8'h00, 1);
  endtask

  task automatic test_capture();
    do_req(0, 1'b1, 2'd0, 8'h11, 1);
    do_req(0, 1'b0, 2'd0, 8'h00, 1);
    do_req(0, 1'b0, 2'd3, 8'h00, 1);
  endtask

  task automatic test_hold();
    do_req(0, 1'b1, 2'd3, 8'h3C, 10);
    do_req(0, 1'b0, 2'd3, 8'h00, 1);
    do_req(0, 1'b0, 2'd0, 8'h00, 1);
  endtask

  task automatic test_reset_mid_access();
    do_req(0, 1'b0, 2'd2, 8'h00, 1);
    drive(0, 1'b1, 1'b1, 2'd1, 8'h5A);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero_outputs("reset_mid_access");
    clear_models();
    drive(0, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_zero_outputs("no_ack_after_abort");
    end
    do_req(0, 1'b0, 2'd1, 8'h00, 1);
  endtask

  task automatic test_reset_release_valid();
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 2'd2, 8'h00);
    @(negedge clk);
    clear_models();
    rst = 1'b0;
    do_req(0, 1'b0, 2'd2, 8'h00, 1);
  endtask

  task automatic test_back_to_back();
    do_req(1, 1'b1, 2'd0, 8'h12, 1);
    do_req(1, 1'b0, 2'd0, 8'h00, 1);
    do_req(1, 1'b1, 2'd1, 8'h34, 1);
    do_req(1, 1'b1, 2'd2, 8'h77, 1);
    do_req(1, 1'b0, 2'd1, 8'h00, 1);
    do_req(1, 1'b0, 2'd3, 8'h00, 1);
    do_req(1, 1'b1, 2'd0, 8'h56, 3);
    do_req(1, 1'b0, 2'd0, 8'h00, 1);
    do_req(1, 1'b0, 2'd2, 8'h00, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      do_req(i % 2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             8'($urandom_range(0, 255)), $urandom_range(1, 4));
    end
  endtask

  task automatic test_drain();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending want 0/0", q0.size(), q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_capture();
    test_hold();
    test_reset_mid_access();
    test_reset_release_valid();
    test_back_to_back();
    test_random();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_W, default 8, word width of the storage array and data buses, in bits.
REQ-002 Parameter ADDR_W, default 2, address width; the array SHALL hold 2**ADDR_W words.
REQ-003 Parameter ACCESS_CYCLES, default 2, number of cycles spent in ACCESS; legal range 1..15.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 valid  input  1  request strobe from the initiator FSM; 1 = request present.
REQ-007 rw  input  1  request type, sampled with valid; 1 = write, 0 = read.
REQ-008 addr  input  ADDR_W  word address, sampled with valid.
REQ-009 wdata  input  DATA_W  write data, sampled with valid.
REQ-010 rdata  output  DATA_W  data from the most recently completed read.
REQ-011 ack  output  1  single-cycle completion pulse for the current request.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement four states: IDLE, ACCESS, ACK and HOLD.
REQ-014 IDLE, valid=1 at a rising edge: capture rw/addr/wdata into internal registers, load the cycle counter with ACCESS_CYCLES-1, go to ACCESS.
REQ-015 IDLE, valid=0: remain in IDLE; no array or rdata change.
REQ-016 ACCESS: decrement the counter each edge; when the counter is 0 at an edge, go to ACK, so ACCESS lasts exactly ACCESS_CYCLES cycles.
REQ-017 ACCESS: changes on valid/rw/addr/wdata SHALL be ignored; only the captured values are used.
REQ-018 On the ACCESS->ACK edge, a captured write SHALL store the captured wdata at the captured addr.
REQ-019 On the ACCESS->ACK edge, a captured read SHALL load rdata with array[captured addr].
REQ-020 ack SHALL be 1 only while in ACK, giving one cycle per request; rdata SHALL already be valid in that cycle.
REQ-021 ACK->IDLE if valid=0 at the edge, else ACK->HOLD.
REQ-022 HOLD: remain while valid=1; go to IDLE on the first edge with valid=0; a request held high through completion SHALL never retrigger.
REQ-023 Requests are accepted only in IDLE; valid in ACCESS, ACK or HOLD SHALL NOT start a new access.
REQ-024 Minimum request-to-ack latency: valid sampled at edge 0, ack high in the cycle after edge ACCESS_CYCLES.
REQ-025 rdata SHALL hold its value across writes and idle cycles; only a completing read updates it.
REQ-026 A read from an address written by an earlier completed write SHALL return that written data.
REQ-027 All addresses 0..2**ADDR_W-1 are valid; there is no out-of-range case and no wrap logic.
REQ-028 The counter SHALL be 4 bits wide; ACCESS_CYCLES=1 SHALL give a single ACCESS cycle with no underflow.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, counter=0, ack=0, busy=0, rdata=0, and all array words=0, independent of clk.
REQ-030 Reset during ACCESS SHALL abort the request: no array write and no ack after reset releases.
REQ-031 After rst is released with valid=1, the request SHALL be accepted at the first rising edge, as in REQ-014.

Verification
REQ-032 Reset, then write addr=2 wdata=0xA5 (valid held 1 cycle) -> ack pulses one cycle, 3 cycles after the accept edge (ACCESS_CYCLES=2); busy=1 from the accept edge through ack.
REQ-033 Read addr=2 after REQ-032 -> rdata=0xA5 in the ack cycle; read addr=1 -> rdata=0x00.
REQ-034 Write with valid held high for 10 cycles -> exactly one ack; state stays HOLD until valid=0; array written once.
REQ-035 During ACCESS of a write to addr=0 data=0x11, change addr to 3 and wdata to 0xFF -> addr 0 holds 0x11, addr 3 stays 0x00.
REQ-036 Assert rst mid-ACCESS of a write to addr=1 data=0x5A -> outputs zero at once, no ack; a later read of addr 1 returns 0x00.
REQ-037 ACCESS_CYCLES=1, back-to-back requests with valid low for 1 cycle between them -> each ack arrives 2 cycles after its accept edge, and rdata updates only on reads.
